mant_div_unit: RTL and testbench

MANT_DIV_UNIT -- requirements
Module: mant_div_unit

---
 rtl/mant_div_unit.sv | 190 +++++++++++++++++++
 tb/tb_mant_div_unit.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/mant_div_unit.sv
// mant_div_unit: 3-stage pipelined mantissa divider.
//   S1: reciprocal seed x0 ~ 1/mant2
//   S2: one Newton-Raphson step x1 = x0*(2 - mant2*x0)
//   S3: q = mant1*x1, normalize into [1,2) and adjust the total exponent
// Build option: define DIV_WITH_LUT_EN to take the seed from a ROM indexed by
// the top LUT_IN fraction bits of mant2; otherwise the seed is the linear
// approximation 24/17 - (8/17)*mant2.

module mant_div_unit #(
  parameter int MS      = 14,
  parameter int TE_SIZE = 8,
  parameter int LUT_IN  = 8,
  parameter int LUT_OUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  input  logic [TE_SIZE-1:0]  te1,
  input  logic [TE_SIZE-1:0]  te2,
  input  logic [MS-1:0]       mant1,
  input  logic [MS-1:0]       mant2,
  output logic                valid_out,
  output logic [3*MS-1:0]     mant_out,
  output logic [TE_SIZE-1:0]  te_out,
  output logic                invalid
);

  localparam int FW = MS - 1;        // mantissa fraction bits
  localparam int XW = 3*MS - 4;      // seed width, 1 integer bit
  localparam int XF = XW - 1;        // seed fraction bits
  localparam int PW = MS + XW;       // mant2*x0 width, 2 integer bits
  localparam int PF = FW + XF;       // mant2*x0 fraction bits
  localparam int NW = XW + PW;       // x0*(2-mant2*x0) width
  localparam int NF = XF + PF;       // its fraction bits
  localparam int YW = 2*MS;          // refined reciprocal width, 1 integer bit
  localparam int QW = 3*MS;          // quotient width, 2 integer bits

  localparam logic [XW-1:0] X0_ONE = XW'(1) << XF;
  localparam logic [PW-1:0] TWO_P  = PW'(1) << (PF + 1);

  if (MS < 6 || MS > 30 || LUT_IN < 1 || LUT_OUT < 1) begin : g_bad_cfg
    $error("mant_div_unit: unsupported parameterization");
  end

  // Stage registers
  logic                vld_p1_q, vld_p1_d, inv_p1_q, inv_p1_d;
  logic [TE_SIZE-1:0]  te_p1_q, te_p1_d;
  logic [MS-1:0]       mant1_p1_q, mant1_p1_d, mant2_p1_q, mant2_p1_d;
  logic [XW-1:0]       x0_p1_q, x0_d;
  logic                vld_p2_q, vld_p2_d, inv_p2_q, inv_p2_d;
  logic [TE_SIZE-1:0]  te_p2_q, te_p2_d;
  logic [MS-1:0]       mant1_p2_q, mant1_p2_d;
  logic [YW-1:0]       x1_p2_q, x1_p2_d;
  logic                valid_out_q, valid_out_d, invalid_q, invalid_d;
  logic [QW-1:0]       mant_out_q, mant_out_d;
  logic [TE_SIZE-1:0]  te_out_q, te_out_d;

  // ---------------- S1: reciprocal seed ----------------
`ifdef DIV_WITH_LUT_EN
  localparam int RW = LUT_OUT + LUT_IN + 1;
  localparam int RN = 2**LUT_IN;

  logic [LUT_OUT-1:0]     seed_rom [RN];
  logic [FW+LUT_IN-1:0]   frac_pad;
  logic [LUT_IN-1:0]      lut_addr;
  logic [XW+LUT_OUT-1:0]  lut_wide;

  // Entry i holds floor(2^LUT_OUT / (1 + i/2^LUT_IN)) as a pure fraction;
  // entry 0 would be exactly 1.0 and is substituted below.
  for (genvar gi = 0; gi < RN; gi++) begin : g_rom
    localparam logic [RW-1:0] NUM = RW'(1) << (LUT_OUT + LUT_IN);
    localparam logic [RW-1:0] DEN = (RW'(1) << LUT_IN) + RW'(gi);
    localparam logic [RW-1:0] QUO = NUM / DEN;
    assign seed_rom[gi] = QUO[LUT_OUT-1:0];
  end

  // ROM lookup on the top fraction bits (zero-padded when the mantissa is short)
  always_comb begin
    frac_pad = {mant2[FW-1:0], {LUT_IN{1'b0}}};
    lut_addr = LUT_IN'(frac_pad >> FW);
    lut_wide = {{XW{1'b0}}, seed_rom[lut_addr]} << XF;
    x0_d     = (lut_addr == '0) ? X0_ONE : XW'(lut_wide >> LUT_OUT);
  end
`else
  localparam logic [MS-1:0]   MANT_ONE = {1'b1, {FW{1'b0}}};
  localparam logic [XW+4:0]   K24      = {{XW{1'b0}}, 5'd24};
  localparam logic [XW+4:0]   K8       = {{XW{1'b0}}, 5'd8};
  localparam logic [XW+4:0]   K17      = {{XW{1'b0}}, 5'd17};
  localparam logic [XW+4:0]   SEED_A_W = (K24 << XF) / K17;
  localparam logic [XW+4:0]   SEED_B_W = (K8 << XF) / K17;
  localparam logic [XW-1:0]   SEED_A   = SEED_A_W[XW-1:0];
  localparam logic [XF-1:0]   SEED_B   = SEED_B_W[XF-1:0];

  logic [XF+MS-1:0] seed_prod;

  // Linear seed 24/17 - (8/17)*mant2; mant2 = 1.0 is pinned to exactly 1.0
  always_comb begin
    seed_prod = SEED_B * mant2;
    x0_d      = SEED_A - XW'(seed_prod >> FW);
    if (mant2 == MANT_ONE) x0_d = X0_ONE;
  end
`endif

  // S1 control and operand capture; invalid only flagged for real operations
  always_comb begin
    vld_p1_d   = valid_in;
    inv_p1_d   = valid_in & ~(mant1[MS-1] & mant2[MS-1]);
    te_p1_d    = te1 - te2;
    mant1_p1_d = mant1;
    mant2_p1_d = mant2;
  end

  // ---------------- S2: Newton-Raphson refinement ----------------
  logic [PW-1:0] mx_p1, corr_p1;
  logic [NW-1:0] x1_full_p1;

  // x1 = x0*(2 - mant2*x0); x1 never exceeds 1/mant2, so 1 integer bit suffices
  always_comb begin
    mx_p1      = mant2_p1_q * x0_p1_q;
    corr_p1    = TWO_P - mx_p1;
    x1_full_p1 = x0_p1_q * corr_p1;
    x1_p2_d    = YW'(x1_full_p1 >> (NF - YW + 1));
    vld_p2_d   = vld_p1_q;
    inv_p2_d   = inv_p1_q;
    te_p2_d    = te_p1_q;
    mant1_p2_d = mant1_p1_q;
  end

  // ---------------- S3: multiply and normalize ----------------
  logic [QW-1:0] q_p2;

  // q in (0.5,2): shift up once when the units bit is clear
  always_comb begin
    q_p2        = mant1_p2_q * x1_p2_q;
    valid_out_d = vld_p2_q;
    invalid_d   = inv_p2_q;
    mant_out_d  = q_p2;
    te_out_d    = te_p2_q;
    if (inv_p2_q) begin
      mant_out_d = '0;
      te_out_d   = '0;
    end else if (!q_p2[QW-2]) begin
      mant_out_d = q_p2 << 1;
      te_out_d   = te_p2_q - TE_SIZE'(1);
    end
  end

  // All pipeline state clears on reset so in-flight work is discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q    <= 1'b0;
      inv_p1_q    <= 1'b0;
      te_p1_q     <= '0;
      mant1_p1_q  <= '0;
      mant2_p1_q  <= '0;
      x0_p1_q     <= '0;
      vld_p2_q    <= 1'b0;
      inv_p2_q    <= 1'b0;
      te_p2_q     <= '0;
      mant1_p2_q  <= '0;
      x1_p2_q     <= '0;
      valid_out_q <= 1'b0;
      invalid_q   <= 1'b0;
      mant_out_q  <= '0;
      te_out_q    <= '0;
    end else begin
      vld_p1_q    <= vld_p1_d;
      inv_p1_q    <= inv_p1_d;
      te_p1_q     <= te_p1_d;
      mant1_p1_q  <= mant1_p1_d;
      mant2_p1_q  <= mant2_p1_d;
      x0_p1_q     <= x0_d;
      vld_p2_q    <= vld_p2_d;
      inv_p2_q    <= inv_p2_d;
      te_p2_q     <= te_p2_d;
      mant1_p2_q  <= mant1_p2_d;
      x1_p2_q     <= x1_p2_d;
      valid_out_q <= valid_out_d;
      invalid_q   <= invalid_d;
      mant_out_q  <= mant_out_d;
      te_out_q    <= te_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign invalid   = invalid_q;
  assign mant_out  = mant_out_q;
  assign te_out    = te_out_q;

endmodule

// File: tb/tb_mant_div_unit.sv
// Directed testbench for mant_div_unit at default parameters (MS=14).
module tb_mant_div_unit;

  localparam int MS = 14;
  localparam int TE = 8;
  localparam int QW = 3*MS;
  localparam logic [QW-1:0] ONE_OUT = 42'd1 << 40;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_in = 1'b0;
  logic [TE-1:0] te1 = '0, te2 = '0;
  logic [MS-1:0] mant1 = '0, mant2 = '0;
  logic          valid_out, invalid;
  logic [QW-1:0] mant_out;
  logic [TE-1:0] te_out;

  int checks = 0;
  int failures = 0;

  mant_div_unit #(.MS(MS), .TE_SIZE(TE), .LUT_IN(8), .LUT_OUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in),
    .te1(te1), .te2(te2), .mant1(mant1), .mant2(mant2),
    .valid_out(valid_out), .mant_out(mant_out), .te_out(te_out),
    .invalid(invalid)
  );

  always #5 clk = ~clk;

  // Accuracy vectors: dividend, divisor, te1, te2, expected te_out
  logic [MS-1:0] acc_a  [4] = '{14'h3FFF, 14'h2800, 14'h3555, 14'h2C00};
  logic [MS-1:0] acc_b  [4] = '{14'h2001, 14'h3A00, 14'h2AAA, 14'h3100};
  logic [TE-1:0] acc_e1 [4] = '{8'h05, 8'h00, 8'h07, 8'h14};
  logic [TE-1:0] acc_e2 [4] = '{8'hFD, 8'h00, 8'h02, 8'h04};
  logic [TE-1:0] acc_te [4] = '{8'h08, 8'hFF, 8'h05, 8'h0F};

  // Back-to-back stream (divisor 1.0 or invalid, so results are exact)
  logic          bb_v   [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  logic [MS-1:0] bb_a   [8] = '{14'h2000, 14'h2A55, 14'h3FFF, 14'h3000,
                                14'h1FFF, 14'h2001, 14'h3000, 14'h2000};
  logic [MS-1:0] bb_b   [8] = '{14'h2000, 14'h2000, 14'h2000, 14'h2000,
                                14'h2000, 14'h2000, 14'h0000, 14'h2000};
  logic [TE-1:0] bb_e1  [8] = '{8'h03, 8'h0A, 8'h00, 8'h00, 8'h01, 8'h7F, 8'h02, 8'h80};
  logic [TE-1:0] bb_e2  [8] = '{8'h01, 8'h04, 8'h05, 8'h00, 8'h01, 8'h80, 8'h02, 8'h01};
  logic          bb_inv [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [TE-1:0] bb_te  [8] = '{8'h02, 8'h06, 8'hFB, 8'h00, 8'h00, 8'hFF, 8'h00, 8'h7F};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [MS-1:0] a, input logic [MS-1:0] b,
                       input logic [TE-1:0] e1, input logic [TE-1:0] e2);
    valid_in = v;
    mant1    = a;
    mant2    = b;
    te1      = e1;
    te2      = e2;
  endtask

  // Issue one operation and advance to the cycle its result is visible
  task automatic run_one(input logic [MS-1:0] a, input logic [MS-1:0] b,
                         input logic [TE-1:0] e1, input logic [TE-1:0] e2);
    drive(1'b1, a, b, e1, e2);
    tick;
    valid_in = 1'b0;
    tick;
    tick;
  endtask

  function automatic real norm_quot(input logic [MS-1:0] a, input logic [MS-1:0] b);
    real r;
    r = real'(a) / real'(b);
    if (r < 1.0) r = r * 2.0;
    return r;
  endfunction

  function automatic real tol_for(input real expv);
`ifdef DIV_WITH_LUT_EN
    return 2.0 ** -13;
`else
    return expv * (2.0 ** -8);
`endif
  endfunction

  task automatic test_reset;
    drive(1'b1, 14'h3000, 14'h2000, 8'h01, 8'h00);
    tick;
    tick;
    tick;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    checks++; if (mant_out !== '0) begin failures++; $display("FAIL reset_mant got=%h exp=0", mant_out); end
    checks++; if (te_out !== '0) begin failures++; $display("FAIL reset_te got=%h exp=0", te_out); end
    checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL reset_invalid got=%b exp=0", invalid); end
    drive(1'b0, '0, '0, '0, '0);
    #2 rst_n = 1'b1;
    tick;
    tick;
    tick;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL post_reset_idle got=%b exp=0", valid_out); end
  endtask

  task automatic test_unity;
    run_one(14'h2000, 14'h2000, 8'h03, 8'h01);
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL unity_valid got=%b exp=1", valid_out); end
    checks++; if (mant_out !== ONE_OUT) begin failures++; $display("FAIL unity_mant got=%h exp=%h", mant_out, ONE_OUT); end
    checks++; if (te_out !== 8'h02) begin failures++; $display("FAIL unity_te got=%h exp=02", te_out); end
    checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL unity_invalid got=%b exp=0", invalid); end
    tick;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL unity_valid_drop got=%b exp=0", valid_out); end
    run_one(14'h2A55, 14'h2000, 8'h00, 8'h00);
    checks++; if (mant_out !== ({28'd0, 14'h2A55} << 27)) begin failures++; $display("FAIL div_by_one_mant got=%h exp=%h", mant_out, {28'd0, 14'h2A55} << 27); end
  endtask

  task automatic test_recip;
    real got, expv, tol;
    run_one(14'h2000, 14'h3000, 8'h00, 8'h00);
    got  = real'(mant_out) / (2.0 ** 40);
    expv = 4.0 / 3.0;
    tol  = tol_for(expv);
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL recip_valid got=%b exp=1", valid_out); end
    checks++; if (te_out !== 8'hFF) begin failures++; $display("FAIL recip_te got=%h exp=ff", te_out); end
    checks++; if (got > expv + tol || got < expv - tol) begin failures++; $display("FAIL recip_mant got=%f exp=%f", got, expv); end
  endtask

  task automatic test_accuracy;
    real got, expv, tol;
    for (int i = 0; i < 4; i++) begin
      run_one(acc_a[i], acc_b[i], acc_e1[i], acc_e2[i]);
      got  = real'(mant_out) / (2.0 ** 40);
      expv = norm_quot(acc_a[i], acc_b[i]);
      tol  = tol_for(expv);
      checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL acc%0d_valid got=%b exp=1", i, valid_out); end
      checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL acc%0d_invalid got=%b exp=0", i, invalid); end
      checks++; if (te_out !== acc_te[i]) begin failures++; $display("FAIL acc%0d_te got=%h exp=%h", i, te_out, acc_te[i]); end
      checks++; if (got > expv + tol || got < expv - tol) begin failures++; $display("FAIL acc%0d_mant got=%f exp=%f", i, got, expv); end
    end
  endtask

  task automatic test_invalid;
    run_one(14'h2000, 14'h0000, 8'h05, 8'h01);
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL inv0_valid got=%b exp=1", valid_out); end
    checks++; if (invalid !== 1'b1) begin failures++; $display("FAIL inv0_flag got=%b exp=1", invalid); end
    checks++; if (mant_out !== '0) begin failures++; $display("FAIL inv0_mant got=%h exp=0", mant_out); end
    checks++; if (te_out !== '0) begin failures++; $display("FAIL inv0_te got=%h exp=0", te_out); end
    run_one(14'h1000, 14'h2000, 8'h05, 8'h01);
    checks++; if (invalid !== 1'b1) begin failures++; $display("FAIL inv1_flag got=%b exp=1", invalid); end
    checks++; if (mant_out !== '0) begin failures++; $display("FAIL inv1_mant got=%h exp=0", mant_out); end
    checks++; if (te_out !== '0) begin failures++; $display("FAIL inv1_te got=%h exp=0", te_out); end
  endtask

  task automatic test_wrap;
    real got, expv, tol;
    run_one(14'h2000, 14'h2000, 8'h80, 8'h01);
    checks++; if (te_out !== 8'h7F) begin failures++; $display("FAIL wrap_te got=%h exp=7f", te_out); end
    checks++; if (mant_out !== ONE_OUT) begin failures++; $display("FAIL wrap_mant got=%h exp=%h", mant_out, ONE_OUT); end
    run_one(14'h2000, 14'h3000, 8'h80, 8'h01);
    got  = real'(mant_out) / (2.0 ** 40);
    expv = 4.0 / 3.0;
    tol  = tol_for(expv);
    checks++; if (te_out !== 8'h7E) begin failures++; $display("FAIL wrap_norm_te got=%h exp=7e", te_out); end
    checks++; if (got > expv + tol || got < expv - tol) begin failures++; $display("FAIL wrap_norm_mant got=%f exp=%f", got, expv); end
  endtask

  task automatic test_back_to_back;
    logic [QW-1:0] exp_m;
    int k;
    drive(1'b0, '0, '0, '0, '0);
    tick;
    tick;
    tick;
    for (int c = 0; c < 11; c++) begin
      if (c >= 3) begin
        k = c - 3;
        exp_m = bb_inv[k] ? '0 : ({28'd0, bb_a[k]} << 27);
        checks++; if (valid_out !== bb_v[k]) begin failures++; $display("FAIL b2b%0d_valid got=%b exp=%b", k, valid_out, bb_v[k]); end
        if (bb_v[k]) begin
          checks++; if (invalid !== bb_inv[k]) begin failures++; $display("FAIL b2b%0d_invalid got=%b exp=%b", k, invalid, bb_inv[k]); end
          checks++; if (mant_out !== exp_m) begin failures++; $display("FAIL b2b%0d_mant got=%h exp=%h", k, mant_out, exp_m); end
          checks++; if (te_out !== bb_te[k]) begin failures++; $display("FAIL b2b%0d_te got=%h exp=%h", k, te_out, bb_te[k]); end
        end
      end else begin
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_lead%0d_valid got=%b exp=0", c, valid_out); end
      end
      if (c < 8) drive(bb_v[c], bb_a[c], bb_b[c], bb_e1[c], bb_e2[c]);
      else       drive(1'b0, '0, '0, '0, '0);
      tick;
    end
  endtask

  task automatic test_reset_midstream;
    drive(1'b1, 14'h3000, 14'h2000, 8'h01, 8'h00);
    tick;
    tick;
    tick;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", valid_out); end
    checks++; if (mant_out !== ({28'd0, 14'h3000} << 27)) begin failures++; $display("FAIL mid_pre_mant got=%h exp=%h", mant_out, {28'd0, 14'h3000} << 27); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%b exp=0", valid_out); end
    checks++; if (mant_out !== '0) begin failures++; $display("FAIL mid_rst_mant got=%h exp=0", mant_out); end
    checks++; if (te_out !== '0) begin failures++; $display("FAIL mid_rst_te got=%h exp=0", te_out); end
    checks++; if (invalid !== 1'b0) begin failures++; $display("FAIL mid_rst_invalid got=%b exp=0", invalid); end
    tick;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_hold_valid got=%b exp=0", valid_out); end
    #2 rst_n = 1'b1;
    drive(1'b1, 14'h2800, 14'h2000, 8'h04, 8'h01);
    tick;
    valid_in = 1'b0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_rel1_valid got=%b exp=0", valid_out); end
    tick;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_rel2_valid got=%b exp=0", valid_out); end
    tick;
    checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL mid_new_valid got=%b exp=1", valid_out); end
    checks++; if (mant_out !== ({28'd0, 14'h2800} << 27)) begin failures++; $display("FAIL mid_new_mant got=%h exp=%h", mant_out, {28'd0, 14'h2800} << 27); end
    checks++; if (te_out !== 8'h03) begin failures++; $display("FAIL mid_new_te got=%h exp=03", te_out); end
    tick;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL mid_tail_valid got=%b exp=0", valid_out); end
  endtask

  initial begin
    test_reset;
    test_unity;
    test_recip;
    test_accuracy;
    test_invalid;
    test_wrap;
    test_back_to_back;
    test_reset_midstream;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
